// File: rtl/countdown_pkg.sv
// Shared encodings and defaults for the countdown timer.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HOLD = ST_HOLD,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/countdown_core.sv
// WIDTH-bit loadable down-counter with zero and one detect.
// Priority inside the register: clear, load, decrement; never goes below zero.
module countdown_core
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_one
);

    logic [WIDTH-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && !w_zero) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = w_zero;
    assign o_one   = (r_count == WIDTH'(1));

endmodule

// File: rtl/countdown_timer.sv
// Load-and-count-down timer with valid/ready load and one-cycle expire pulse.
// Define COUNTDOWN_AUTORELOAD_EN for periodic (auto-reload) mode.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // Load handshake: a load is accepted on a rising edge where
    // i_load_valid && o_load_ready && !i_abort; the producer holds
    // i_load_valid and i_load_value stable until that edge.
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    input  logic             i_abort,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_expire,
    output logic [1:0]       o_dbg_state
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_expire;
    logic             w_expire_next;
    logic             w_core_clear;
    logic             w_core_load;
    logic             w_core_dec;
    logic [WIDTH-1:0] w_core_value;
    logic             w_zero;
    logic             w_one;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;

    // On a periodic reload w_core_value is r_reload itself, so this only changes on a real load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reload <= '0;
        end else if (w_core_load) begin
            r_reload <= w_core_value;
        end
    end
`endif

    countdown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_core_clear),
        .i_load      (w_core_load),
        .i_load_value(w_core_value),
        .i_dec       (w_core_dec),
        .o_count     (o_count),
        .o_zero      (w_zero),
        .o_one       (w_one)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_expire <= w_expire_next;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_expire_next = 1'b0;
        w_core_clear  = 1'b0;
        w_core_load   = 1'b0;
        w_core_dec    = 1'b0;
        w_core_value  = i_load_value;
        if (i_abort) begin
            w_next_state = IDLE;
            w_core_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_load_valid) begin
                        w_core_load = 1'b1;
                        if (i_load_value == '0) begin
                            w_expire_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                            w_next_state  = RUN;
`else
                            w_next_state  = DONE;
`endif
                        end else begin
                            w_next_state = RUN;
                        end
                    end
                end
                RUN: begin
                    if (!i_enable) begin
                        w_next_state = HOLD;
                    end else if (w_one || w_zero) begin
                        // A zero count in RUN only occurs in periodic mode after loading 0.
                        w_expire_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        w_core_load   = 1'b1;
                        w_core_value  = r_reload;
`else
                        w_core_dec    = 1'b1;
                        w_next_state  = DONE;
`endif
                    end else begin
                        w_core_dec = 1'b1;
                    end
                end
                HOLD: begin
                    if (i_enable) begin
                        w_next_state = RUN;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign o_load_ready = (r_state == IDLE) || (r_state == DONE);
    assign o_busy       = (r_state == RUN) || (r_state == HOLD);
    assign o_expire     = r_expire;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer plus hand-written reset, latency sequences.
module tb_countdown_timer;
    import countdown_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         enable;
    logic         abort_i;
    logic [W-1:0] count;
    logic         busy;
    logic         expire;
    logic [1:0]   dbg_state;

    int n_checks;
    int n_pass;

    typedef struct {
        logic         valid;
        logic [W-1:0] value;
        logic         en;
        logic         ab;
        logic [W-1:0] e_count;
        logic         e_expire;
        logic         e_busy;
        logic         e_ready;
        logic [1:0]   e_state;
    } vec_t;

    vec_t vecs[$];

    countdown_timer #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load_valid(load_valid),
        .o_load_ready(load_ready),
        .i_load_value(load_value),
        .i_enable    (enable),
        .i_abort     (abort_i),
        .o_count     (count),
        .o_busy      (busy),
        .o_expire    (expire),
        .o_dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+4:0] obs();
        return {count, expire, busy, load_ready, dbg_state};
    endfunction

    task automatic check(input string name, input logic [W+4:0] act, input logic [W+4:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] val, input logic en, input logic ab);
        load_valid = v;
        load_value = val;
        enable     = en;
        abort_i    = ab;
    endtask

    task automatic step(input logic v, input logic [W-1:0] val, input logic en, input logic ab);
        drive(v, val, en, ab);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input logic [W-1:0] val, input logic en, input logic ab,
                       input logic [W-1:0] c, input logic ex, input logic bu, input logic rd,
                       input logic [1:0] st);
        vec_t t;
        t.valid = v; t.value = val; t.en = en; t.ab = ab;
        t.e_count = c; t.e_expire = ex; t.e_busy = bu; t.e_ready = rd; t.e_state = st;
        vecs.push_back(t);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // Vector table: inputs applied before an edge, outputs expected after it.
`ifdef COUNTDOWN_AUTORELOAD_EN
        add(1, 2, 1, 0,  2, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  2, 1, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  2, 1, 1, 0, ST_RUN);
        add(1, 5, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 1,  0, 0, 0, 1, ST_IDLE);
        add(1, 0, 1, 0,  0, 1, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  0, 1, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  0, 1, 1, 0, ST_RUN);
        add(0, 0, 0, 0,  0, 0, 1, 0, ST_HOLD);
        add(0, 0, 0, 1,  0, 0, 0, 1, ST_IDLE);
`else
        // load 3, free running
        add(1, 3, 1, 0,  3, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  2, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  0, 1, 0, 1, ST_DONE);
        add(0, 0, 1, 0,  0, 0, 0, 1, ST_DONE);
        // load 5, pause after two decrements
        add(1, 5, 1, 0,  5, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  4, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  3, 0, 1, 0, ST_RUN);
        add(0, 0, 0, 0,  3, 0, 1, 0, ST_HOLD);
        add(0, 0, 0, 0,  3, 0, 1, 0, ST_HOLD);
        add(0, 0, 0, 0,  3, 0, 1, 0, ST_HOLD);
        add(0, 0, 0, 0,  3, 0, 1, 0, ST_HOLD);
        add(0, 0, 1, 0,  3, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  2, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  0, 1, 0, 1, ST_DONE);
        add(0, 0, 1, 0,  0, 0, 0, 1, ST_DONE);
        // load 0: immediate expire, never busy
        add(1, 0, 1, 0,  0, 1, 0, 1, ST_DONE);
        add(0, 0, 1, 0,  0, 0, 0, 1, ST_DONE);
        // load 8, abort together with load on the third cycle
        add(1, 8, 1, 0,  8, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  7, 0, 1, 0, ST_RUN);
        add(1, 8, 1, 1,  0, 0, 0, 1, ST_IDLE);
        add(0, 0, 1, 0,  0, 0, 0, 1, ST_IDLE);
        // abort beats a load offered in IDLE
        add(1, 9, 1, 1,  0, 0, 0, 1, ST_IDLE);
        // load 1: shortest non-zero count
        add(1, 1, 1, 0,  1, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  0, 1, 0, 1, ST_DONE);
        // load with enable low goes straight to HOLD next
        add(1, 2, 0, 0,  2, 0, 1, 0, ST_RUN);
        add(0, 0, 0, 0,  2, 0, 1, 0, ST_HOLD);
        add(0, 0, 0, 1,  0, 0, 0, 1, ST_IDLE);
        // load offered while running is ignored
        add(1, 4, 1, 0,  4, 0, 1, 0, ST_RUN);
        add(1, 7, 1, 0,  3, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 1,  0, 0, 0, 1, ST_IDLE);
        // largest value
        add(1, 32'hFFFF_FFFF, 1, 0,  32'hFFFF_FFFF, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 0,  32'hFFFF_FFFE, 0, 1, 0, ST_RUN);
        add(0, 0, 1, 1,  0, 0, 0, 1, ST_IDLE);
`endif

        // Reset state while held
        #12;
        check("reset_hold", {count, expire, busy, dbg_state}, {{W{1'b0}}, 1'b0, 1'b0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", obs(), {{W{1'b0}}, 1'b0, 1'b0, 1'b1, ST_IDLE});

        // Reset pulse mid-countdown
        step(1'b1, 10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("midcount_before_reset", obs(), {W'(6), 1'b0, 1'b1, 1'b0, ST_RUN});
        #2;
        rst = 1'b1;
        #1;
        check("midcount_async_reset", {count, expire, busy, dbg_state}, {{W{1'b0}}, 1'b0, 1'b0, ST_IDLE});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midcount_after_release", obs(), {{W{1'b0}}, 1'b0, 1'b0, 1'b1, ST_IDLE});

        // Latency: expire exactly N cycles after count first shows N
        step(1'b1, 6, 1'b1, 1'b0);
        check("latency_load", {count, expire}, {W'(6), 1'b0});
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (expire === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("latency_cycles", W'(lat), W'(6));
        step(1'b0, '0, 1'b1, 1'b1);
        check("latency_abort", obs(), {{W{1'b0}}, 1'b0, 1'b0, 1'b1, ST_IDLE});

        // Table
        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].value, vecs[i].en, vecs[i].ab);
            check($sformatf("vec%0d", i), obs(),
                  {vecs[i].e_count, vecs[i].e_expire, vecs[i].e_busy, vecs[i].e_ready, vecs[i].e_state});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
